// File: rtl/mdio_if.sv
// MDIO management bus bundle: host request/response signals plus the PHY-side
// serial pins, seen from the controller (slave) and the host/PHY side (master).
interface mdio_if;
   logic        MDIO_START;
   logic [31:0] T_DATA;
   logic        MDIO_IN;
   logic        MDC;
   logic        MDIO_OUT;
   logic        MDIO_OE;
   logic        MDIO_DONE;
   logic [15:0] RD_DATA;
   logic        DATA_RDY;

   modport master (
      output MDIO_START, T_DATA, MDIO_IN,
      input  MDC, MDIO_OUT, MDIO_OE, MDIO_DONE, RD_DATA, DATA_RDY
   );

   modport slave (
      input  MDIO_START, T_DATA, MDIO_IN,
      output MDC, MDIO_OUT, MDIO_OE, MDIO_DONE, RD_DATA, DATA_RDY
   );
endinterface

// File: rtl/mdio_controller.sv
// Clause-22 style MDIO master: shifts a 32-bit frame out on MDIO, one MDC period
// per bit, and for reads releases the line after the address and captures 16 bits.
module mdio_controller #(
   parameter int HALF = 1
) (
   input  logic CLK,
   input  logic RESET,
   mdio_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ_ADDR,
      READ_DATA,
      DONE
   } state_t;

   localparam logic [2:0] HALF_M1 = 3'(HALF - 1);

   state_t      state_q;
   logic [31:0] shreg_q;
   logic [15:0] rd_shift_q;
   logic [15:0] rd_data_q;
   logic [2:0]  half_q;
   logic [4:0]  bit_q;
   logic        mdc_q;
   logic        oe_q;
   logic        done_q;
   logic        rdy_q;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         rd_shift_q <= '0;
         rd_data_q  <= '0;
         half_q     <= '0;
         bit_q      <= '0;
         mdc_q      <= 1'b0;
         oe_q       <= 1'b0;
         done_q     <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         rdy_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.MDIO_START) begin
                  shreg_q <= bus.T_DATA;
                  oe_q    <= 1'b1;
                  mdc_q   <= 1'b0;
                  half_q  <= '0;
                  bit_q   <= '0;
                  state_q <= (bus.T_DATA[29:28] == 2'b10) ? READ_ADDR : WRITE;
               end
            end
            WRITE, READ_ADDR, READ_DATA: begin
               if (half_q != HALF_M1) begin
                  half_q <= half_q + 3'd1;
               end else if (!mdc_q) begin
                  // Rising MDC: the PHY's data bit has been stable for a full low half.
                  half_q <= '0;
                  mdc_q  <= 1'b1;
                  if (state_q == READ_DATA && bit_q >= 5'd16)
                     rd_shift_q <= {rd_shift_q[14:0], bus.MDIO_IN};
               end else begin
                  half_q <= '0;
                  mdc_q  <= 1'b0;
                  if (bit_q == 5'd31) begin
                     state_q <= DONE;
                     oe_q    <= 1'b0;
                     done_q  <= 1'b1;
                     if (state_q == READ_DATA) begin
                        rd_data_q <= rd_shift_q;
                        rdy_q     <= 1'b1;
                     end
                  end else begin
                     bit_q   <= bit_q + 5'd1;
                     shreg_q <= {shreg_q[30:0], 1'b0};
                     if (state_q == READ_ADDR && bit_q == 5'd13) begin
                        state_q <= READ_DATA;
                        oe_q    <= 1'b0;
                     end
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // The line is only driven while OE is high, so the data bit is gated by it.
   assign bus.MDIO_OUT  = shreg_q[31] & oe_q;
   assign bus.MDC       = mdc_q;
   assign bus.MDIO_OE   = oe_q;
   assign bus.MDIO_DONE = done_q;
   assign bus.RD_DATA   = rd_data_q;
   assign bus.DATA_RDY  = rdy_q;

endmodule

// File: tb/tb_mdio_controller.sv
// Bench for mdio_controller: two instances (HALF=1 and HALF=2), a per-cycle waveform
// model computed from bit index arithmetic, table vectors plus random frames.
module tb_mdio_controller;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        start = 1'b0;
   logic        sel = 1'b0;
   logic        mdio_in = 1'b0;
   logic [31:0] tdata = '0;

   always #5 CLK = ~CLK;

   mdio_if bus1 ();
   mdio_if bus2 ();

   assign bus1.MDIO_START = start & ~sel;
   assign bus2.MDIO_START = start & sel;
   assign bus1.T_DATA     = tdata;
   assign bus2.T_DATA     = tdata;
   assign bus1.MDIO_IN    = mdio_in;
   assign bus2.MDIO_IN    = mdio_in;

   mdio_controller #(.HALF(1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1));
   mdio_controller #(.HALF(2)) dut2 (.CLK(CLK), .RESET(RESET), .bus(bus2));

   // {MDC, OE, OUT, DONE, RDY, RD_DATA} of the selected instance
   wire [20:0] obs = sel ?
      {bus2.MDC, bus2.MDIO_OE, bus2.MDIO_OUT, bus2.MDIO_DONE, bus2.DATA_RDY, bus2.RD_DATA} :
      {bus1.MDC, bus1.MDIO_OE, bus1.MDIO_OUT, bus1.MDIO_DONE, bus1.DATA_RDY, bus1.RD_DATA};

   typedef struct {
      logic [31:0] tdata;
      logic [15:0] phy;
      logic        sel;
      int          glitch;
      bit          glitch_done;
      int          rst_at;
      logic [15:0] exp_rd;
   } vec_t;

   int          tests = 0;
   int          fails = 0;
   logic [15:0] rd_model [2];

   task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_frame(input vec_t v);
      int          h;
      int          n;
      int          b;
      logic        rd;
      logic        oe;
      logic [20:0] e;
      h  = v.sel ? 2 : 1;
      n  = 64 * h;
      rd = (v.tdata[29:28] == 2'b10);
      $display("[TB] frame sel=%0d tdata=%h phy=%h %s", v.sel, v.tdata, v.phy, rd ? "read" : "write");
      @(negedge CLK);
      sel   = v.sel;
      tdata = v.tdata;
      start = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      start = 1'b0;
      for (int c = 0; c <= n; c++) begin
         if (c > 0) @(negedge CLK);
         b = c / (2 * h);
         if (c == v.glitch) begin
            start = 1'b1;
            tdata = ~v.tdata;
         end else if (c == v.glitch + 1) begin
            start = 1'b0;
         end
         if (c == v.rst_at) begin
            RESET = 1'b0;
            #1;
            rd_model[0] = '0;
            rd_model[1] = '0;
            check("reset_immediate", obs, 21'h0);
            repeat (2) @(negedge CLK);
            check("reset_hold", obs, 21'h0);
            RESET = 1'b1;
            @(negedge CLK);
            check("post_reset_idle", obs, 21'h0);
            return;
         end
         mdio_in = (rd && b >= 16 && c < n) ? v.phy[31 - b] : 1'($urandom_range(0, 1));
         if (c < n) begin
            oe = !rd || (b < 14);
            e  = {((c % (2 * h)) >= h), oe, oe & v.tdata[31 - b], 1'b0, 1'b0, rd_model[v.sel]};
            check("frame_cycle", obs, e);
         end else begin
            if (rd) rd_model[v.sel] = v.phy;
            e = {1'b0, 1'b0, 1'b0, 1'b1, rd, rd_model[v.sel]};
            check("done_cycle", obs, e);
         end
      end
      if (v.glitch_done) begin
         start = 1'b1;
         tdata = 32'h6FFF_FFFF;
         @(negedge CLK);
         start = 1'b0;
         for (int i = 0; i < 4; i++) begin
            check("idle_after_done", obs, {5'b0, rd_model[v.sel]});
            @(negedge CLK);
         end
      end
      check("rd_data_end", {5'b0, obs[15:0]}, {5'b0, v.exp_rd});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [8];
      vec_t v;
      rd_model[0] = '0;
      rd_model[1] = '0;
      // tdata, phy, sel, glitch cycle, done glitch, reset cycle, expected RD_DATA
      vecs[0] = '{32'h53D6_43AE, 16'h0000, 1'b0, -1, 1'b0, -1, 16'h0000};
      vecs[1] = '{32'h61D4_0000, 16'hBEEF, 1'b0, -1, 1'b0, -1, 16'hBEEF};
      vecs[2] = '{32'h53D6_43AE, 16'h0000, 1'b0, 21, 1'b1, -1, 16'hBEEF};
      vecs[3] = '{32'h61D4_0000, 16'h1234, 1'b0, -1, 1'b0, 41, 16'h0000};
      vecs[4] = '{32'h53D6_43AE, 16'h0000, 1'b0, -1, 1'b0, -1, 16'h0000};
      vecs[5] = '{32'h5FFF_0001, 16'h0000, 1'b1, -1, 1'b0, -1, 16'h0000};
      vecs[6] = '{32'h6ABC_0000, 16'hCAFE, 1'b1, -1, 1'b0, -1, 16'hCAFE};
      vecs[7] = '{32'h0234_5678, 16'h0000, 1'b0, -1, 1'b1, -1, 16'h0000};

      RESET = 1'b0;
      repeat (3) @(negedge CLK);
      sel = 1'b0;
      #1 check("reset_state_h1", obs, 21'h0);
      sel = 1'b1;
      #1 check("reset_state_h2", obs, 21'h0);
      @(negedge CLK);
      RESET = 1'b1;

      foreach (vecs[i]) run_frame(vecs[i]);

      // OP=11 is sent as a write too
      v = '{32'h3234_5678, 16'h0000, 1'b1, -1, 1'b0, -1, 16'hCAFE};
      run_frame(v);

      for (int i = 0; i < 16; i++) begin
         v.sel   = 1'($urandom_range(0, 1));
         v.tdata = $urandom;
         if ($urandom_range(0, 1) == 1) v.tdata[29:28] = 2'b10;
         v.phy         = 16'($urandom);
         v.glitch      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1;
         v.glitch_done = 1'($urandom_range(0, 1));
         v.rst_at      = -1;
         v.exp_rd      = (v.tdata[29:28] == 2'b10) ? v.phy : rd_model[v.sel];
         run_frame(v);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mdio_controller.md
MDIO_CONTROLLER -- requirements
Module: mdio_controller

Interface
REQ-001 SHALL have parameter: HALF, 1, MDC half-period in CLK cycles (legal values 1 to 8).
REQ-002 SHALL have port: CLK  in  1  system clock; all logic on rising edge.
REQ-003 SHALL have port: RESET  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: MDIO_START  in  1  request pulse; accepted only in IDLE.
REQ-005 SHALL have port: T_DATA  in  32  frame: [31:30] ST, [29:28] OP, [27:23] PHYAD, [22:18] REGAD, [17:16] TA, [15:0] data.
REQ-006 SHALL have port: MDIO_IN  in  1  serial data from PHY during read.
REQ-007 SHALL have port: MDC  out  1  management clock to PHY.
REQ-008 SHALL have port: MDIO_OUT  out  1  serial data to PHY, MSB first.
REQ-009 SHALL have port: MDIO_OE  out  1  high while the controller drives MDIO_OUT.
REQ-010 SHALL have port: MDIO_DONE  out  1  one-CLK pulse at end of frame.
REQ-011 SHALL have port: RD_DATA  out  16  last read data.
REQ-012 SHALL have port: DATA_RDY  out  1  one-CLK pulse when RD_DATA updates.

Function
REQ-013 SHALL implement states IDLE, WRITE, READ_ADDR, READ_DATA and DONE.
REQ-014 In IDLE, SHALL hold MDC=0, MDIO_OE=0 and MDIO_OUT=0.
REQ-015 SHALL latch T_DATA into a 32-bit shift register when MDIO_START=1 at edge k in IDLE.
REQ-016 At edge k, SHALL go to READ_ADDR if T_DATA[29:28]=10, otherwise to WRITE; OP 00 and 11 are sent as writes.
REQ-017 SHALL ignore MDIO_START in every state other than IDLE.
REQ-018 SHALL use one MDC period per bit: MDC low for HALF CLK cycles, then high for HALF CLK cycles.
REQ-019 SHALL drive each new bit on MDIO_OUT at the start of its low half, so the bit is stable across the MDC rising edge.
REQ-020 After edge k, SHALL output MDIO_OE=1, MDIO_OUT=T_DATA[31] and MDC=0; MDC first rises HALF cycles later.
REQ-021 In WRITE, SHALL drive all 32 bits (31 down to 0) with MDIO_OE=1.
REQ-022 In READ_ADDR, SHALL drive bits 31..18 (14 periods) with MDIO_OE=1, then enter READ_DATA.
REQ-023 In READ_DATA, SHALL hold MDIO_OE=0 and MDIO_OUT=0 for 18 MDC periods: 2 TA periods, then 16 data periods.
REQ-024 In READ_DATA, SHALL sample MDIO_IN on the CLK edge where MDC goes 0->1, during the 16 data periods only, shifting MSB first into an internal register.
REQ-025 After the final MDC high half, SHALL spend one cycle in DONE with MDIO_DONE=1, MDC=0 and MDIO_OE=0, then return to IDLE.
REQ-026 A frame SHALL last 64*HALF CLK cycles from edge k+1 to DONE, for both write and read.
REQ-027 On a read, in the DONE cycle, SHALL update RD_DATA with the sampled word and pulse DATA_RDY=1; a write SHALL leave RD_DATA unchanged and DATA_RDY=0.
REQ-028 SHALL hold RD_DATA until the next read completes.
REQ-029 MDIO_START in the DONE cycle SHALL be ignored; the earliest accepted request is the first IDLE cycle after DONE.
REQ-030 MDC SHALL toggle only outside IDLE and DONE, and SHALL never glitch.

Reset
REQ-031 While RESET=0, SHALL immediately force state=IDLE and MDC=0, MDIO_OUT=0, MDIO_OE=0, MDIO_DONE=0, DATA_RDY=0, RD_DATA=0x0000, and clear all counters and shift registers.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no MDIO_DONE pulse.
REQ-033 After RESET returns to 1, the first MDIO_START SHALL be accepted normally.

Verification
REQ-034 Write, HALF=1: T_DATA=0x53D643AE -> 32 bits on MDIO_OUT, stable at MDC rising edges, reading 01 01 00111 10101 10 0x43AE; MDIO_OE=1 throughout; MDIO_DONE after 64 cycles; DATA_RDY=0.
REQ-035 Read: T_DATA=0x61D40000 with PHY model driving 0xBEEF after TA -> MDIO_OE=1 for 14 periods then 0; RD_DATA=0xBEEF; DATA_RDY and MDIO_DONE pulse together once.
REQ-036 MDIO_START pulsed at bit 10 of a write, and again in the DONE cycle -> both ignored; frame unchanged; no second frame starts.
REQ-037 RESET=0 at bit 20 of a read -> all outputs 0 at once; no MDIO_DONE; a following write of 0x53D643AE completes correctly.
REQ-038 HALF=2, back-to-back write then read -> MDC period of 4 CLK; each frame lasts 128 cycles; read result correct.
